// File: rtl/fetch_unit_pkg.sv
// Shared fetch/control definitions: opcodes, immediate extraction, fetch FSM
// states and the fetch-queue entry layout.
package fetch_unit_pkg;

  localparam logic [6:0] BRANCH  = 7'b1100011;
  localparam logic [6:0] JAL_Op  = 7'b1101111;
  localparam logic [6:0] JALR_Op = 7'b1100111;

  localparam int unsigned QUEUE_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        pred;
  } fetch_entry_t;

  function automatic logic [63:0] b_imm(input logic [31:0] inst);
    return {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [63:0] j_imm(input logic [31:0] inst);
    return {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction memory port, decode-side queue head, redirect
// and branch-resolution update. master = fetch unit, slave = environment.
interface fetch_unit_if;
  logic        out_imem_req;
  logic [63:0] out_imem_addr;
  logic        in_imem_ack;
  logic [31:0] in_imem_data;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_prediction;
  logic        out_valid;
  logic        in_ready;
  logic        in_flush;
  logic [63:0] in_redirect_pc;
  logic        in_bht_upd_en;
  logic [63:0] in_bht_upd_pc;
  logic        in_bht_upd_taken;

  modport master (
    output out_imem_req, out_imem_addr, out_inst, out_pc, out_prediction, out_valid,
    input  in_imem_ack, in_imem_data, in_ready, in_flush, in_redirect_pc,
           in_bht_upd_en, in_bht_upd_pc, in_bht_upd_taken
  );

  modport slave (
    input  out_imem_req, out_imem_addr, out_inst, out_pc, out_prediction, out_valid,
    output in_imem_ack, in_imem_data, in_ready, in_flush, in_redirect_pc,
           in_bht_upd_en, in_bht_upd_pc, in_bht_upd_taken
  );
endinterface

// File: rtl/fetch_unit_bht.sv
// Branch history table: 2-bit saturating counters, combinational read port
// (returns pre-update value) and one synchronous update port.
module branch_history_table #(
  parameter int unsigned IDX_W = 6
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0][1:0] ctr;

  assign rd_ctr = ctr[rd_idx];

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      ctr <= {ENTRIES{2'b01}};
    end else if (upd_en) begin
      if (upd_taken && (ctr[upd_idx] != 2'b11)) begin
        ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
      end else if (!upd_taken && (ctr[upd_idx] != 2'b00)) begin
        ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single outstanding imem request, next-PC
// prediction and a 2-entry instruction queue. FETCH_BHT_EN enables the BHT.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned BHT_IDX_W = 6
) (
  input logic          in_clk,
  input logic          in_rst,
  fetch_unit_if.master bus
);

  fetch_state_e state, state_n;
  logic [63:0]  pc;
  logic [63:0]  req_addr;
  logic [63:0]  issue_addr;
  logic [63:0]  pred_npc;
  logic         pred_taken;
  logic         bht_taken;
  logic         push, pop, issue, valid;
  logic [1:0]   count, count_n;
  logic         rd_ptr, wr_ptr;
  fetch_entry_t queue [QUEUE_DEPTH];
  fetch_entry_t head;

`ifdef FETCH_BHT_EN
  logic [1:0] bht_ctr;

  // Indexed by the address of the instruction being returned, not by pc.
  branch_history_table #(.IDX_W(BHT_IDX_W)) u_bht (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .rd_idx   (req_addr[BHT_IDX_W+1:2]),
    .rd_ctr   (bht_ctr),
    .upd_en   (bus.in_bht_upd_en),
    .upd_idx  (bus.in_bht_upd_pc[BHT_IDX_W+1:2]),
    .upd_taken(bus.in_bht_upd_taken)
  );

  assign bht_taken = bht_ctr[1];
`else
  assign bht_taken = 1'b0;
`endif

  always_comb begin
    pred_npc   = req_addr + 64'd4;
    pred_taken = 1'b0;
    case (bus.in_imem_data[6:0])
      BRANCH: begin
        if (bht_taken) begin
          pred_npc   = req_addr + b_imm(bus.in_imem_data);
          pred_taken = 1'b1;
        end
      end
      JAL_Op: begin
        pred_npc   = req_addr + j_imm(bus.in_imem_data);
        pred_taken = 1'b1;
      end
      JALR_Op: pred_npc = req_addr + 64'd4;
      default: ;
    endcase
  end

  assign valid   = (count != 2'd0);
  assign push    = (state == WAIT) && bus.in_imem_ack && !bus.in_flush;
  assign pop     = valid && bus.in_ready && !bus.in_flush;
  assign count_n = count + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    issue_addr = pc;
    case (state)
      IDLE: begin
        if (!bus.in_flush && (count_n < 2'd2)) issue = 1'b1;
      end
      WAIT: begin
        if (bus.in_flush) begin
          state_n = bus.in_imem_ack ? IDLE : DROP;
        end else if (bus.in_imem_ack) begin
          issue_addr = pred_npc;
          if (count_n < 2'd2) issue = 1'b1;
          else                state_n = IDLE;
        end
      end
      DROP: begin
        if (bus.in_imem_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (issue) state_n = WAIT;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= '0;
      count    <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      queue[0] <= '0;
      queue[1] <= '0;
    end else begin
      state <= state_n;
      if (issue) req_addr <= issue_addr;
      if (bus.in_flush) begin
        pc     <= bus.in_redirect_pc & ~64'h3;
        count  <= '0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          queue[wr_ptr] <= '{inst: bus.in_imem_data, pc: req_addr, pred: pred_taken};
          wr_ptr        <= ~wr_ptr;
          pc            <= pred_npc;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count_n;
      end
    end
  end

  assign head               = queue[rd_ptr];
  assign bus.out_inst       = head.inst;
  assign bus.out_pc         = head.pc;
  assign bus.out_prediction = head.pred;
  assign bus.out_valid      = valid;
  assign bus.out_imem_req   = (state != IDLE);
  assign bus.out_imem_addr  = req_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of fetched entries plus
// table-driven next-PC/prediction vectors and hand-written corner sequences.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(64'h1000), .BHT_IDX_W(6)) dut (
    .in_clk(clk),
    .in_rst(rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        pred;
  } sb_t;

  sb_t sb [$];

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    int          n_taken;
    int          n_not;
    bit          ack_upd;
    logic [63:0] next_bht;
    logic        pred_bht;
    logic [63:0] next_nobht;
    logic        pred_nobht;
  } vec_t;

  vec_t vecs [11];

  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack(input logic [31:0] data, input logic [63:0] exp_pc,
                        input logic exp_pred, input bit track);
    bus.in_imem_ack  = 1'b1;
    bus.in_imem_data = data;
    if (track) sb.push_back('{inst: data, pc: exp_pc, pred: exp_pred});
    step();
    bus.in_imem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.in_imem_ack   = 1'b0;
    bus.in_flush      = 1'b0;
    bus.in_bht_upd_en = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Scoreboard: compare every entry the decode side accepts.
  always @(negedge clk) begin
    if (rst || bus.in_flush) begin
      sb.delete();
    end else if (bus.out_valid && bus.in_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h with nothing expected", bus.out_pc);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("sb_inst", {32'h0, bus.out_inst}, {32'h0, e.inst});
        check("sb_pc",   bus.out_pc, e.pc);
        check("sb_pred", {63'h0, bus.out_prediction}, {63'h0, e.pred});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{64'h1000, 32'h0000_0013, 0, 0, 1'b0, 64'h1004, 1'b0, 64'h1004, 1'b0};
    vecs[1]  = '{64'h1000, 32'h0000_0463, 2, 0, 1'b0, 64'h1008, 1'b1, 64'h1004, 1'b0};
    vecs[2]  = '{64'h1000, 32'h0000_0463, 0, 0, 1'b0, 64'h1004, 1'b0, 64'h1004, 1'b0};
    vecs[3]  = '{64'h2000, 32'h1000_006F, 0, 0, 1'b0, 64'h2100, 1'b1, 64'h2100, 1'b1};
    vecs[4]  = '{64'h2000, 32'hFFDF_F06F, 0, 0, 1'b0, 64'h1FFC, 1'b1, 64'h1FFC, 1'b1};
    vecs[5]  = '{64'h0000, 32'hFFDF_F06F, 0, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFC, 1'b1};
    vecs[6]  = '{64'h2000, 32'h0000_8067, 0, 0, 1'b0, 64'h2004, 1'b0, 64'h2004, 1'b0};
    vecs[7]  = '{64'h3010, 32'hFE00_1CE3, 4, 1, 1'b0, 64'h3008, 1'b1, 64'h3014, 1'b0};
    vecs[8]  = '{64'h3010, 32'hFE00_1CE3, 3, 2, 1'b0, 64'h3014, 1'b0, 64'h3014, 1'b0};
    vecs[9]  = '{64'h1000, 32'h0000_0463, 1, 0, 1'b0, 64'h1008, 1'b1, 64'h1004, 1'b0};
    vecs[10] = '{64'h1000, 32'h0000_0463, 2, 0, 1'b1, 64'h1008, 1'b1, 64'h1004, 1'b0};

    bus.in_imem_ack      = 1'b0;
    bus.in_imem_data     = '0;
    bus.in_ready         = 1'b1;
    bus.in_flush         = 1'b0;
    bus.in_redirect_pc   = '0;
    bus.in_bht_upd_en    = 1'b0;
    bus.in_bht_upd_pc    = '0;
    bus.in_bht_upd_taken = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("rst_req",   {63'h0, bus.out_imem_req}, 64'h0);
    check("rst_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rst_inst",  {32'h0, bus.out_inst}, 64'h0);
    check("rst_pc",    bus.out_pc, 64'h0);
    check("rst_pred",  {63'h0, bus.out_prediction}, 64'h0);

    // Streaming NOPs with a single-cycle-ack memory.
    rst = 1'b0;
    step();
    check("first_req",   {63'h0, bus.out_imem_req}, 64'h1);
    check("first_valid", {63'h0, bus.out_valid}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      check("stream_addr", bus.out_imem_addr, 64'h1000 + 64'(4 * i));
      do_ack(NOP, 64'h1000 + 64'(4 * i), 1'b0, 1'b1);
      check("stream_valid", {63'h0, bus.out_valid}, 64'h1);
    end
    check("stream_next", bus.out_imem_addr, 64'h100C);

    // Backpressure: queue fills, request stops, FIFO order kept on release.
    bus.in_ready = 1'b0;
    do_ack(NOP, 64'h100C, 1'b0, 1'b1);
    check("full_req", {63'h0, bus.out_imem_req}, 64'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("full_req_hold", {63'h0, bus.out_imem_req}, 64'h0);
      check("full_head",     bus.out_pc, 64'h1008);
    end
    bus.in_ready = 1'b1;
    step();
    check("drain_req",  {63'h0, bus.out_imem_req}, 64'h1);
    check("drain_addr", bus.out_imem_addr, 64'h1010);
    check("drain_head", bus.out_pc, 64'h100C);
    step();
    check("drain_empty", {63'h0, bus.out_valid}, 64'h0);

    // Flush with entries queued and a request outstanding; late ack dropped.
    bus.in_ready = 1'b0;
    do_reset();
    do_ack(NOP, 64'h1000, 1'b0, 1'b1);
    check("fl_valid_pre", {63'h0, bus.out_valid}, 64'h1);
    bus.in_flush       = 1'b1;
    bus.in_redirect_pc = 64'h3002;
    step();
    bus.in_flush = 1'b0;
    check("fl_cleared",  {63'h0, bus.out_valid}, 64'h0);
    check("fl_drop_req", {63'h0, bus.out_imem_req}, 64'h1);
    check("fl_old_addr", bus.out_imem_addr, 64'h1004);
    step();
    do_ack(32'h1000_006F, 64'h0, 1'b0, 1'b0);
    check("fl_idle_req", {63'h0, bus.out_imem_req}, 64'h0);
    check("fl_no_push",  {63'h0, bus.out_valid}, 64'h0);
    step();
    check("fl_new_req",  {63'h0, bus.out_imem_req}, 64'h1);
    check("fl_new_addr", bus.out_imem_addr, 64'h3000);
    bus.in_ready = 1'b1;
    do_ack(NOP, 64'h3000, 1'b0, 1'b1);
    check("fl_next_addr", bus.out_imem_addr, 64'h3004);
    step();

    // Reset mid-request: an ack on the first edge after reset is ignored.
    rst = 1'b1;
    step();
    rst              = 1'b0;
    bus.in_imem_ack  = 1'b1;
    bus.in_imem_data = 32'h1000_006F;
    step();
    bus.in_imem_ack = 1'b0;
    check("rstmid_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rstmid_req",   {63'h0, bus.out_imem_req}, 64'h1);
    check("rstmid_addr",  bus.out_imem_addr, 64'h1000);
    step();
    check("rstmid_valid2", {63'h0, bus.out_valid}, 64'h0);

    // Table-driven next-PC / prediction vectors.
    for (int i = 0; i < 11; i++) begin
      logic [63:0] exp_next;
      logic        exp_pred;
      int          n;
`ifdef FETCH_BHT_EN
      exp_next = vecs[i].next_bht;
      exp_pred = vecs[i].pred_bht;
`else
      exp_next = vecs[i].next_nobht;
      exp_pred = vecs[i].pred_nobht;
`endif
      bus.in_ready = 1'b1;
      do_reset();
      n = vecs[i].n_taken + vecs[i].n_not;
      for (int k = 0; k < n; k++) begin
        bus.in_bht_upd_en    = 1'b1;
        bus.in_bht_upd_pc    = vecs[i].pc;
        bus.in_bht_upd_taken = (k < vecs[i].n_taken);
        if (k == n - 1) begin
          bus.in_flush       = 1'b1;
          bus.in_redirect_pc = vecs[i].pc;
        end
        step();
      end
      bus.in_bht_upd_en = 1'b0;
      if (n == 0) begin
        bus.in_flush       = 1'b1;
        bus.in_redirect_pc = vecs[i].pc;
        step();
      end
      bus.in_flush = 1'b0;
      do_ack(32'h0, 64'h0, 1'b0, 1'b0);
      check($sformatf("vec%0d_idle", i), {63'h0, bus.out_imem_req}, 64'h0);
      step();
      check($sformatf("vec%0d_redir", i), bus.out_imem_addr, vecs[i].pc);
      if (vecs[i].ack_upd) begin
        bus.in_bht_upd_en    = 1'b1;
        bus.in_bht_upd_pc    = vecs[i].pc;
        bus.in_bht_upd_taken = 1'b0;
      end
      do_ack(vecs[i].inst, vecs[i].pc, exp_pred, 1'b1);
      bus.in_bht_upd_en = 1'b0;
      check($sformatf("vec%0d_req", i),  {63'h0, bus.out_imem_req}, 64'h1);
      check($sformatf("vec%0d_next", i), bus.out_imem_addr, exp_next);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
